// File: rtl/button_event.sv
// rtl/button_event.sv - button press/release/long-press/auto-repeat event generator
// Optional auto-repeat in LONG state is enabled by defining BUTTON_REPEAT_EN.
module button_event #(
    parameter int LONG_CYCLES   = 200,
    parameter int REPEAT_CYCLES = 50,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {IDLE, HOLD, LONG} state_t;

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [1:0]        mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              held_q, held_d;

    logic mask_done, rise, fall, long_term;

    // Edges are ignored until the synchronizer has refilled after reset, so a
    // button already held at reset release cannot look like a fresh press.
    assign mask_done = (mask_q == 2'd3);
    assign rise      = s2_q & ~s3_q & mask_done;
    assign fall      = s3_q & ~s2_q;
    assign long_term = (cnt_q == LONG_TERM);
    assign mask_d    = mask_done ? mask_q : mask_q + 2'd1;
    assign held_d    = s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            mask_q <= 2'd0;
        end else begin
            s1_q   <= pb_debounced;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            mask_q <= mask_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = HOLD;
            HOLD: begin
                if (fall)           state_d = IDLE;
                else if (long_term) state_d = LONG;
            end
            LONG:    if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Release is tested first so it wins over any terminal count that cycle.
    always_comb begin
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                press_d = rise;
            end
            HOLD: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (long_term) begin
                    long_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
`ifdef BUTTON_REPEAT_EN
                    if (cnt_q == REP_TERM) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
`ifdef BUTTON_REPEAT_EN
    assign repeat_pulse  = repeat_q;
`else
    assign repeat_pulse  = 1'b0;
`endif
    assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - randomized and directed check of button_event against an event-level model
module tb_button_event;

    localparam int LONG_C = 8;
    localparam int REP_C  = 4;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pb  = 1'b0;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    always #5 clk = ~clk;

    button_event #(.LONG_CYCLES(LONG_C), .REPEAT_CYCLES(REP_C), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .pb_debounced  (pb),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: e = edges since reset release, hist[k] = pb sampled at edge k+1,
    // act = a press is in progress, d = edges elapsed since the press edge.
    int e;
    bit hist[$];
    bit act;
    int d;

    int n_press, n_rel, n_long, n_rep, first_press, first_long, last_rel;
    int rep_at[$];

    task automatic chk(input string name, input logic a, input logic x);
        vectors++;
        if (a !== x) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, e, a, x);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int x);
        vectors++;
        if (a != x) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, a, x);
        end
    endtask

    task automatic clear_model();
        e = 0;
        hist.delete();
        act = 1'b0;
        d = 0;
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
        first_press = -1; first_long = -1; last_rel = -1;
        rep_at.delete();
    endtask

    task automatic model_and_check();
        bit lvl, prv, x_press, x_rel, x_long, x_rep;
        lvl = (e >= 3) ? hist[e-3] : 1'b0;
        prv = (e >= 4) ? hist[e-4] : 1'b0;
        x_press = 0; x_rel = 0; x_long = 0; x_rep = 0;
        if (!act) begin
            if (e >= 4 && lvl && !prv) begin
                x_press = 1; act = 1; d = 0;
            end
        end else begin
            d++;
            if (!lvl) begin
                x_rel = 1; act = 0;
            end else if (d == LONG_C) begin
                x_long = 1;
            end else if (REP_EN && d > LONG_C && (d - LONG_C) % REP_C == 0) begin
                x_rep = 1;
            end
        end
        chk("press_pulse", press_pulse, x_press);
        chk("release_pulse", release_pulse, x_rel);
        chk("long_pulse", long_pulse, x_long);
        chk("repeat_pulse", repeat_pulse, x_rep);
        chk("held", held, lvl);
        if (press_pulse) begin n_press++; if (first_press < 0) first_press = e; end
        if (release_pulse) begin n_rel++; last_rel = e; end
        if (long_pulse) begin n_long++; if (first_long < 0) first_long = e; end
        if (repeat_pulse) begin n_rep++; rep_at.push_back(e); end
    endtask

    task automatic run_cycle(input bit v);
        @(negedge clk);
        pb = v;
        @(posedge clk);
        e++;
        hist.push_back(v);
        #1;
        model_and_check();
    endtask

    task automatic run_n(input bit v, input int n);
        for (int i = 0; i < n; i++) run_cycle(v);
    endtask

    task automatic do_reset(input bit v);
        @(negedge clk);
        rst = 1'b1;
        pb  = v;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        clear_model();
        #1;
        chk("reset_press", press_pulse, 1'b0);
        chk("reset_held", held, 1'b0);

        // Short press of 5 cycles
        do_reset(1'b0);
        run_n(0, 6); run_n(1, 5); run_n(0, 10);
        chk_int("short_first_press", first_press, 9);
        chk_int("short_press_count", n_press, 1);
        chk_int("short_release_edge", last_rel, 14);
        chk_int("short_long_count", n_long, 0);

        // Long hold of 20 cycles
        do_reset(1'b0);
        run_n(0, 6); run_n(1, 20); run_n(0, 8);
        chk_int("long_first_press", first_press, 9);
        chk_int("long_first_long", first_long, 17);
        chk_int("long_repeat_count", n_rep, REP_EN ? 2 : 0);
`ifdef BUTTON_REPEAT_EN
        chk_int("long_repeat1", rep_at[0], 21);
        chk_int("long_repeat2", rep_at[1], 25);
`endif
        chk_int("long_release_edge", last_rel, 29);

        // Release on the same cycle the counter reaches terminal
        do_reset(1'b0);
        run_n(0, 6); run_n(1, 8); run_n(0, 8);
        chk_int("term_long_count", n_long, 0);
        chk_int("term_release_edge", last_rel, 17);
        chk_int("term_release_count", n_rel, 1);

        // Single-cycle pulse
        do_reset(1'b0);
        run_n(0, 6); run_n(1, 1); run_n(0, 6);
        chk_int("single_press", first_press, 9);
        chk_int("single_release", last_rel, 10);

        // Asynchronous reset while in LONG with the button still held
        do_reset(1'b0);
        run_n(0, 6); run_n(1, 14);
        chk_int("midhold_long", first_long, 17);
        #2 rst = 1'b1;
        #1;
        chk("async_press", press_pulse, 1'b0);
        chk("async_release", release_pulse, 1'b0);
        chk("async_long", long_pulse, 1'b0);
        chk("async_repeat", repeat_pulse, 1'b0);
        chk("async_held", held, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_model();
        run_n(1, 10);
        chk_int("held_after_reset_press", n_press, 0);
        run_n(0, 3); run_n(1, 3); run_n(0, 6);
        chk_int("repress_after_reset", n_press, 1);

        // Randomized runs of held / released levels
        do_reset(1'b0);
        for (int r = 0; r < 150; r++) begin
            bit v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = (r % 5 == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 10));
            run_n(v, len);
        end
        run_n(0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 200, clk cycles of continuous hold from press_pulse to long_pulse (minimum 2).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 50, clk cycles between auto-repeat pulses (minimum 2).
REQ-003 SHALL have parameter CNT_W, default 16, counter width; LONG_CYCLES and REPEAT_CYCLES SHALL fit in CNT_W bits.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pb_debounced  input  1  debounced button level from the debounce stage (1 = pressed), asynchronous to clk.
REQ-007 SHALL have port press_pulse  output  1  one-cycle pulse on press.
REQ-008 SHALL have port release_pulse  output  1  one-cycle pulse on release.
REQ-009 SHALL have port long_pulse  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
REQ-010 SHALL have port repeat_pulse  output  1  one-cycle auto-repeat pulse while held past long press.
REQ-011 SHALL have port held  output  1  registered synchronized button level.

Function
REQ-012 SHALL synchronize pb_debounced through two flip-flops (s1, s2); a third flop s3 holds the previous s2 for edge detection.
REQ-013 SHALL register all outputs; a 0->1 input change set up before edge N SHALL give press_pulse=1 for exactly the cycle after edge N+2 (latency 3 edges).
REQ-014 SHALL implement FSM states IDLE, HOLD, LONG; reset state IDLE.
REQ-015 IDLE: on s2 rising edge -> HOLD, assert press_pulse, clear counter to 0.
REQ-016 HOLD: counter increments each cycle while s2=1; when counter reaches LONG_CYCLES-1 -> LONG, assert long_pulse, clear counter, so long_pulse occurs exactly LONG_CYCLES cycles after press_pulse.
REQ-017 LONG: counter increments each cycle while s2=1; behaviour of repeat per REQ-026/027.
REQ-018 HOLD or LONG: on s2 falling edge -> IDLE, assert release_pulse, clear counter.
REQ-019 Release SHALL take priority: if release and counter terminal occur in the same cycle, only release_pulse asserts, no long_pulse or repeat_pulse.
REQ-020 At most one of press_pulse, release_pulse, long_pulse, repeat_pulse SHALL be high in any cycle.
REQ-021 held SHALL equal s2 delayed by one clk (aligned with press_pulse/release_pulse).
REQ-022 Counter SHALL never wrap: it clears at every terminal count and in IDLE holds at 0.
REQ-023 A press shorter than LONG_CYCLES SHALL produce only press_pulse then release_pulse.

Reset
REQ-024 rst=1 SHALL immediately clear s1, s2, s3, counter, all outputs to 0 and FSM to IDLE, independent of clk.
REQ-025 If button is held when rst deasserts, no press_pulse SHALL occur until s2 has been observed 0 then 1 (s3 resets to 0 but FSM requires s2 rising from a synchronized 0; synchronizer refill SHALL be masked for 3 cycles after reset release).

Configuration
REQ-026 With macro BUTTON_REPEAT_EN defined, LONG state SHALL assert repeat_pulse when counter reaches REPEAT_CYCLES-1 and clear counter, i.e. first repeat REPEAT_CYCLES cycles after long_pulse, then every REPEAT_CYCLES cycles while held.
REQ-027 Without BUTTON_REPEAT_EN, repeat_pulse SHALL be tied to 0, LONG state counter SHALL hold at 0, and LONG exits only on release.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-028 Short press: pb_debounced high 5 cycles -> press_pulse once at edge 3, release_pulse once, no long_pulse.
REQ-029 Long hold 20 cycles, BUTTON_REPEAT_EN defined -> long_pulse 8 cycles after press_pulse, repeat_pulse at +4 and +8 after long_pulse, then release_pulse.
REQ-030 Same stimulus without BUTTON_REPEAT_EN -> long_pulse at +8, repeat_pulse never high, release_pulse on release.
REQ-031 Release on the cycle counter hits 7 -> release_pulse only, no long_pulse.
REQ-032 rst pulsed mid-hold (state LONG) -> all outputs 0 asynchronously, FSM IDLE; held button after reset gives no press_pulse until released and re-pressed.
REQ-033 Single-cycle 1 on pb_debounced -> exactly one press_pulse and one release_pulse, never simultaneous.
